// File: rtl/dmem_pkg.sv
// dmem_pkg: shared port encodings, widths and request bundle for the data-memory arbiter
package dmem_pkg;
   localparam logic [1:0] PORT_NONE = 2'd0;
   localparam logic [1:0] PORT_CPU  = 2'd1;
   localparam logic [1:0] PORT_DMA  = 2'd2;
   localparam int DMEM_ADDR_W = 32;
   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_MASK_W = 4;
   typedef struct packed {
      logic                   we;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
      logic [DMEM_MASK_W-1:0] mask;
   } dmem_req_t;
endpackage

// File: rtl/rr_burst_grant.sv
// rr_burst_grant: round-robin grant between CPU and DMA with a bounded burst lock
module rr_burst_grant
   import dmem_pkg::*;
#(
   parameter int  BURST_MAX = 4,
   localparam int CNT_W     = $clog2(BURST_MAX + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_valid,
   input  logic       dma_valid,
   output logic [1:0] grant
);
   logic [1:0]       owner_q, owner_d, gnt_port;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             locked, pick_dma, gnt_cpu, gnt_dma;
   always_comb begin
      locked   = cnt_q >= CNT_W'(BURST_MAX);
      // contention: the current owner keeps the port until it has used its burst
      pick_dma = (cpu_valid && dma_valid)
               ? ((owner_q == PORT_DMA) ? !locked : ((owner_q == PORT_CPU) && locked))
               : dma_valid;
      gnt_cpu  = !rst && cpu_valid && !pick_dma;
      gnt_dma  = !rst && dma_valid && pick_dma;
      gnt_port = gnt_cpu ? PORT_CPU : gnt_dma ? PORT_DMA : PORT_NONE;
      owner_d  = gnt_port;
      cnt_d    = (gnt_port == PORT_NONE) ? '0
               : (gnt_port != owner_q)   ? CNT_W'(1)
               : locked                  ? cnt_q
               : cnt_q + CNT_W'(1);
   end
   assign grant = {gnt_dma, gnt_cpu};
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= PORT_NONE;
         cnt_q   <= '0;
      end else begin
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between CPU and DMA with 1-cycle responses
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int BURST_MAX = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cpu_req_valid,
   output logic                   cpu_req_ready,
   input  logic                   cpu_req_we,
   input  logic [DMEM_ADDR_W-1:0] cpu_req_addr,
   input  logic [DMEM_DATA_W-1:0] cpu_req_wdata,
   input  logic [DMEM_MASK_W-1:0] cpu_req_mask,
   output logic                   cpu_rsp_valid,
   output logic [DMEM_DATA_W-1:0] cpu_rsp_rdata,
   input  logic                   dma_req_valid,
   output logic                   dma_req_ready,
   input  logic                   dma_req_we,
   input  logic [DMEM_ADDR_W-1:0] dma_req_addr,
   input  logic [DMEM_DATA_W-1:0] dma_req_wdata,
   input  logic [DMEM_MASK_W-1:0] dma_req_mask,
   output logic                   dma_rsp_valid,
   output logic [DMEM_DATA_W-1:0] dma_rsp_rdata,
   output logic                   mem_MemRW,
   output logic [DMEM_ADDR_W-1:0] mem_addr,
   output logic [DMEM_DATA_W-1:0] mem_dataW,
   output logic [DMEM_MASK_W-1:0] mem_MemWriteMask,
   input  logic [DMEM_DATA_W-1:0] mem_dataR
);
   logic [1:0]             grant, rsp_sel_q, rsp_sel_d;
   logic [DMEM_DATA_W-1:0] rsp_data_q, rsp_data_d;
   dmem_req_t              cpu_req, dma_req, sel_req;
   rr_burst_grant #(.BURST_MAX(BURST_MAX)) u_grant (
      .clk       (clk),
      .rst       (rst),
      .cpu_valid (cpu_req_valid),
      .dma_valid (dma_req_valid),
      .grant     (grant)
   );
   always_comb begin
      cpu_req    = {cpu_req_we, cpu_req_addr, cpu_req_wdata, cpu_req_mask};
      dma_req    = {dma_req_we, dma_req_addr, dma_req_wdata, dma_req_mask};
      sel_req    = grant[0] ? cpu_req : grant[1] ? dma_req : '0;
      rsp_sel_d  = grant[0] ? PORT_CPU : grant[1] ? PORT_DMA : PORT_NONE;
      rsp_data_d = (|grant && !sel_req.we) ? mem_dataR : '0;
   end
   assign cpu_req_ready    = grant[0];
   assign dma_req_ready    = grant[1];
   assign mem_MemRW        = sel_req.we;
   assign mem_addr         = sel_req.addr;
   assign mem_dataW        = sel_req.wdata;
   assign mem_MemWriteMask = sel_req.mask;
   // responses are masked during rst so an in-flight one is dropped immediately
   assign cpu_rsp_valid    = !rst && (rsp_sel_q == PORT_CPU);
   assign dma_rsp_valid    = !rst && (rsp_sel_q == PORT_DMA);
   assign cpu_rsp_rdata    = cpu_rsp_valid ? rsp_data_q : '0;
   assign dma_rsp_rdata    = dma_rsp_valid ? rsp_data_q : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_sel_q  <= PORT_NONE;
         rsp_data_q <= '0;
      end else begin
         rsp_sel_q  <= rsp_sel_d;
         rsp_data_q <= rsp_data_d;
      end
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory port (64 KB, asynchronous read, synchronous byte-masked write) between two requesters: the CPU load/store path and a DMA/debug loader.
- Arbitrates at most one access per cycle and drives the memory's control, address, write-data and byte-mask inputs.
- Registers each read result and returns it to the winning requester with a one-cycle response.
- Round-robin with a bounded burst lock, so neither port can starve the other.

Parameters:
- BURST_MAX, 4, maximum consecutive grants to one port while the other port is waiting (≥1).
- CNT_W, $clog2(BURST_MAX+1), width of the beat counter (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  CPU request granted this cycle.
- cpu_req_we  in  1  1 = store, 0 = load.
- cpu_req_addr  in  32  byte address.
- cpu_req_wdata  in  32  store data.
- cpu_req_mask  in  4  byte write mask.
- cpu_rsp_valid  out  1  response for the CPU request granted last cycle.
- cpu_rsp_rdata  out  32  read word; 0 for a store ack.
- dma_req_valid, dma_req_ready, dma_req_we, dma_req_addr, dma_req_wdata, dma_req_mask, dma_rsp_valid, dma_rsp_rdata: same directions, widths and meanings as the CPU port.
- mem_MemRW  out  1  write enable to the memory.
- mem_addr  out  32  address to the memory.
- mem_dataW  out  32  write data to the memory.
- mem_MemWriteMask  out  4  byte mask to the memory.
- mem_dataR  in  32  asynchronous read data from the memory.

Behaviour:
- State:
  - owner ∈ {NONE, CPU, DMA}.
  - cnt (CNT_W bits): consecutive grants to owner.
  - rsp_sel ∈ {NONE, CPU, DMA}: which port gets the next response.
  - rsp_data (32 bits): captured read data.
- Reset values: owner = NONE, cnt = 0, rsp_sel = NONE, rsp_data = 0. Therefore both rsp_valid = 0 and both rdata = 0.
- Reset mid-operation: an in-flight response is dropped and no ready is asserted. The memory outputs are 0 during the rst cycle, so no write occurs.
- Grant decision (combinational, same cycle):
  - Neither valid → no grant.
  - Exactly one valid → grant that port.
  - Both valid, owner = X and cnt < BURST_MAX → grant X.
  - Both valid, owner = X and cnt ≥ BURST_MAX → grant the other port.
  - Both valid, owner = NONE → grant CPU.
- req_ready is asserted only for the granted port. It depends combinationally on req_valid; requesters must not make valid depend on ready.
- Memory drive:
  - Granted port: mem_addr, mem_dataW and mem_MemWriteMask are that port's fields; mem_MemRW = granted port's we.
  - No grant: all four memory outputs are 0.
- Owner/cnt update at each edge:
  - Grant to owner → cnt saturating-increments at BURST_MAX.
  - Grant to a different port → owner = that port, cnt = 1.
  - No grant → owner = NONE, cnt = 0.
- Response:
  - Every accepted request (load or store) produces exactly one rsp_valid pulse on its own port, in the cycle after acceptance. Latency is 1.
  - A load returns rsp_rdata = mem_dataR sampled at the accept edge.
  - A store returns rsp_rdata = 0; its write is committed at that same edge.
- The non-responding port holds rsp_valid = 0 and rsp_rdata = 0.
- Throughput: one access per cycle and back-to-back accepts are allowed. There is no response backpressure; requesters must accept a response in that cycle.
- Read-after-write by the other port in the next cycle sees the new data, because the memory write is synchronous and the read is asynchronous.
- Address, mask and alignment are passed through unchecked.

Decomposition:
- Shared package (dmem_pkg):
  - owner/port encoding constants: PORT_NONE = 2'd0, PORT_CPU = 2'd1, PORT_DMA = 2'd2.
  - DMEM_ADDR_W = 32, DMEM_DATA_W = 32, DMEM_MASK_W = 4.
- One natural sub-module: rr_burst_grant, holding the owner/cnt state and the grant logic (inputs: two valids; outputs: one-hot grant). The datapath muxing and response register stay in dmem_arbiter.

Test Plan:
1. Reset is held 2 cycles with both valids = 1 → both readies = 0, mem_MemRW = 0, both rsp_valid = 0. After release, CPU is granted first.
2. CPU only: store addr 0x100, wdata 0xDEADBEEF, mask 4'b1111; next cycle load 0x100 → rsp_valid in cycles +1 and +2, load rdata = 0xDEADBEEF, store ack rdata = 0.
3. Byte-lane write through the arbiter: DMA stores 0x000000AA with mask 4'b0001 to a word holding 0x11223344, then CPU loads it → CPU rdata = 0x112233AA.
4. BURST_MAX = 4, both valid continuously for 16 cycles → grant sequence CPU×4, DMA×4, CPU×4, DMA×4. Each response arrives on the correct port one cycle after its grant.
5. Lone requester past the limit: DMA valid for 10 cycles with CPU idle → DMA granted all 10 and cnt saturates at 4. CPU then asserts → CPU is granted on the next cycle.
6. rst is asserted the cycle after a CPU load is accepted → cpu_rsp_valid stays 0 and owner returns to NONE. A post-reset simultaneous request is granted to CPU.
